// File: rtl/morse_digit_tx_pkg.sv
// morse_pkg: shared state encoding, digit pattern table and unit constants
// for the Morse digit transmitter.
package morse_pkg;

    // Sequencer states. TAIL is only reachable when the tail gap is built.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int TAIL_UNITS = 3;
    localparam int NUM_SYMS   = 5;

    // Five-symbol code per digit, bit 4 is sent first, 1 = dash.
    // Entries are listed from digit 9 down to digit 0.
    localparam logic [9:0][4:0] PATTERN = {
        5'b11110,  // 9  ----.
        5'b11100,  // 8  ---..
        5'b11000,  // 7  --...
        5'b10000,  // 6  -....
        5'b00000,  // 5  .....
        5'b00001,  // 4  ....-
        5'b00011,  // 3  ...--
        5'b00111,  // 2  ..---
        5'b01111,  // 1  .----
        5'b11111   // 0  -----
    };

    // Symbol type at position idx (0 = first sent) of a pattern.
    function automatic logic sym_is_dash(input logic [4:0] pat, input logic [2:0] idx);
        return pat[3'd4 - idx];
    endfunction

endpackage

// File: rtl/morse_digit_tx_if.sv
// Request/status bundle between a digit source and the Morse transmitter.
interface morse_digit_tx_if;
    logic        start;
    logic [3:0]  digit;
    logic        busy;
    logic        done;
    logic        err;
    logic        tone_on;
    logic        is_dash;
    logic [11:0] audio_out;

    // Digit source side
    modport master (
        output start, digit,
        input  busy, done, err, tone_on, is_dash, audio_out
    );

    // Transmitter side
    modport slave (
        input  start, digit,
        output busy, done, err, tone_on, is_dash, audio_out
    );
endinterface

// File: rtl/morse_digit_tx_tone_gen.sv
// morse_tone_gen: square-wave sample generator. A restart puts the phase
// in the high half so every mark begins at full amplitude; the phase then
// flips every TONE_HALF cycles while enable is held. The sample is
// registered and driven to 0 whenever enable is low.
module morse_tone_gen #(
    parameter int          TONE_HALF = 50_000,
    parameter logic [11:0] AMPLITUDE = 12'd2047
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        enable,
    output logic [11:0] sample
);

    localparam int            TW        = $clog2(TONE_HALF + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(TONE_HALF - 1);

    logic [TW-1:0] r_cnt;
    logic          r_phase;
    logic [11:0]   r_sample;

    // Phase counter and sample register; restart and enable describe the
    // state of the coming cycle, so the sample lines up with tone_on.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_sample <= '0;
        end else if (restart) begin
            r_cnt    <= HALF_LOAD;
            r_phase  <= 1'b1;
            r_sample <= AMPLITUDE;
        end else if (enable) begin
            if (r_cnt == '0) begin
                r_cnt    <= HALF_LOAD;
                r_phase  <= ~r_phase;
                r_sample <= r_phase ? '0 : AMPLITUDE;
            end else begin
                r_cnt    <= r_cnt - TW'(1);
                r_sample <= r_phase ? AMPLITUDE : '0;
            end
        end else begin
            r_sample <= '0;
        end
    end

    assign sample = r_sample;

endmodule

// File: rtl/morse_digit_tx.sv
// morse_digit_tx: sends a decimal digit as five Morse symbols on a square
// wave tone. Optional build macro MORSE_TAIL_GAP_EN appends a silent
// three-unit TAIL after the last mark before returning to IDLE.
module morse_digit_tx
    import morse_pkg::*;
#(
    parameter int          UNIT_CYCLES = 10_000_000,
    parameter int          TONE_HALF   = 50_000,
    parameter logic [11:0] AMPLITUDE   = 12'd2047
) (
    input  logic             clock,
    input  logic             rst_n,
    morse_digit_tx_if.slave  bus
);

    localparam int             UCW       = $clog2(DASH_UNITS * UNIT_CYCLES);
    localparam logic [UCW-1:0] DOT_LOAD  = UCW'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [UCW-1:0] DASH_LOAD = UCW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [UCW-1:0] GAP_LOAD  = UCW'(UNIT_CYCLES - 1);
`ifdef MORSE_TAIL_GAP_EN
    localparam logic [UCW-1:0] TAIL_LOAD = UCW'(TAIL_UNITS * UNIT_CYCLES - 1);
`endif
    localparam logic [2:0]     LAST_IDX  = 3'(NUM_SYMS - 1);

    state_t         r_state;
    logic [UCW-1:0] r_cnt;
    logic [2:0]     r_idx;
    logic [4:0]     r_pat;
    logic           r_is_dash;
    logic           r_done;
    logic           r_err;

    state_t         w_nxt_state;
    logic [UCW-1:0] w_nxt_cnt;
    logic [2:0]     w_nxt_idx;
    logic [4:0]     w_nxt_pat;
    logic           w_nxt_is_dash;
    logic           w_nxt_done;
    logic           w_nxt_err;
    logic           w_enter_mark;
    logic           w_dash_sym;
    logic [11:0]    w_sample;

    // State register and sequencer counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_pat     <= '0;
            r_is_dash <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_idx     <= w_nxt_idx;
            r_pat     <= w_nxt_pat;
            r_is_dash <= w_nxt_is_dash;
            r_done    <= w_nxt_done;
            r_err     <= w_nxt_err;
        end
    end

    // Next-state logic: the unit counter is loaded on every state entry
    // and the state moves on the cycle it reads 0.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_idx     = r_idx;
        w_nxt_pat     = r_pat;
        w_nxt_is_dash = r_is_dash;
        w_nxt_done    = 1'b0;
        w_nxt_err     = 1'b0;
        w_enter_mark  = 1'b0;
        w_dash_sym    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.digit <= 4'd9) begin
                        w_nxt_pat     = PATTERN[bus.digit];
                        w_nxt_idx     = '0;
                        w_dash_sym    = sym_is_dash(w_nxt_pat, 3'd0);
                        w_nxt_is_dash = w_dash_sym;
                        w_nxt_cnt     = w_dash_sym ? DASH_LOAD : DOT_LOAD;
                        w_nxt_state   = MARK;
                        w_enter_mark  = 1'b1;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end

            MARK: begin
                if (r_cnt == '0) begin
                    if (r_idx == LAST_IDX) begin
`ifdef MORSE_TAIL_GAP_EN
                        w_nxt_state = TAIL;
                        w_nxt_cnt   = TAIL_LOAD;
`else
                        w_nxt_state = IDLE;
                        w_nxt_done  = 1'b1;
`endif
                    end else begin
                        w_nxt_state = GAP;
                        w_nxt_cnt   = GAP_LOAD;
                    end
                end else begin
                    w_nxt_cnt = r_cnt - UCW'(1);
                end
            end

            GAP: begin
                if (r_cnt == '0) begin
                    w_nxt_idx     = r_idx + 3'd1;
                    w_dash_sym    = sym_is_dash(r_pat, w_nxt_idx);
                    w_nxt_is_dash = w_dash_sym;
                    w_nxt_cnt     = w_dash_sym ? DASH_LOAD : DOT_LOAD;
                    w_nxt_state   = MARK;
                    w_enter_mark  = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - UCW'(1);
                end
            end

            TAIL: begin
`ifdef MORSE_TAIL_GAP_EN
                if (r_cnt == '0) begin
                    w_nxt_state = IDLE;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt - UCW'(1);
                end
`else
                w_nxt_state = IDLE;
`endif
            end

            default: w_nxt_state = IDLE;
        endcase
    end

    morse_tone_gen #(
        .TONE_HALF (TONE_HALF),
        .AMPLITUDE (AMPLITUDE)
    ) u_tone (
        .clock   (clock),
        .rst_n   (rst_n),
        .restart (w_enter_mark),
        .enable  (w_nxt_state == MARK),
        .sample  (w_sample)
    );

    assign bus.busy      = (r_state != IDLE);
    assign bus.tone_on   = (r_state == MARK);
    assign bus.is_dash   = r_is_dash;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.audio_out = w_sample;

endmodule
